// File: rtl/wb_queue.sv
// Pending register-write queue: buffers results until the register-file write port
// is free, and forwards the newest pending value for decode-stage lookups.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_dst,
    input  logic [31:0]     in_data,
    input  logic            drain_en,
    output logic            RegWr,
    output logic [4:0]      RW,
    output logic [31:0]     busW,
    input  logic [4:0]      RA,
    input  logic [4:0]      RB,
    output logic            hitA,
    output logic            hitB,
    output logic [31:0]     fwdA,
    output logic [31:0]     fwdB,
    output logic [PTRW:0]   count
);

    localparam logic [PTRW:0] FULL_CNT = (PTRW + 1)'(DEPTH);

    logic [4:0]      dst_mem  [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic            empty;
    logic            accept;
    logic            enq;
    logic            deq;

    assign empty    = (count == '0);
    assign in_ready = (count != FULL_CNT);
    assign accept   = in_valid & in_ready;
    // Writes to r0 are accepted from the producer but never stored.
    assign enq      = accept & (in_dst != 5'd0);
    assign RegWr    = ~empty & drain_en;
    assign deq      = RegWr;
    assign RW       = empty ? 5'd0  : dst_mem[head];
    assign busW     = empty ? 32'd0 : data_mem[head];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTRW'(1);
            if (deq) head <= head + PTRW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTRW + 1)'(1);
                2'b01:   count <= count - (PTRW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payloads are only meaningful inside the count-defined window, so no reset.
    always_ff @(posedge clock) begin
        if (enq) begin
            dst_mem[tail]  <= in_dst;
            data_mem[tail] <= in_data;
        end
    end

    // Scan oldest to newest so the last match (closest to tail) wins.
    logic [PTRW-1:0] idx;
    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        fwdA = 32'd0;
        fwdB = 32'd0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTRW'(i);
            if ((PTRW + 1)'(i) < count) begin
                if ((RA != 5'd0) && (dst_mem[idx] == RA)) begin
                    hitA = 1'b1;
                    fwdA = data_mem[idx];
                end
                if ((RB != 5'd0) && (dst_mem[idx] == RB)) begin
                    hitB = 1'b1;
                    fwdB = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with a queue-based reference model; every cycle the
// drain port, occupancy and lookup outputs are compared against the model.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_dst;
    logic [31:0]   in_data;
    logic          drain_en;
    logic          RegWr;
    logic [4:0]    RW;
    logic [31:0]   busW;
    logic [4:0]    RA;
    logic [4:0]    RB;
    logic          hitA;
    logic          hitB;
    logic [31:0]   fwdA;
    logic [31:0]   fwdB;
    logic [PTRW:0] count;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dst   (in_dst),
        .in_data  (in_data),
        .drain_en (drain_en),
        .RegWr    (RegWr),
        .RW       (RW),
        .busW     (busW),
        .RA       (RA),
        .RB       (RB),
        .hitA     (hitA),
        .hitB     (hitB),
        .fwdA     (fwdA),
        .fwdB     (fwdB),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [4:0] r, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = 32'd0;
        if (r != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].dst == r) begin
                    hit = 1'b1;
                    val = q[i].data;
                end
            end
        end
    endtask

    task automatic offer(input logic [4:0] d, input logic [31:0] v);
        in_valid = 1'b1;
        in_dst   = d;
        in_data  = v;
    endtask

    // Check the DUT against the model before the next edge, then advance the model.
    task automatic step();
        int          sz;
        logic        exp_wr;
        logic        acc;
        logic        h;
        logic [31:0] f;
        ent_t        e;
        #1;
        sz     = q.size();
        exp_wr = (sz != 0) && drain_en;
        acc    = in_valid && (sz < DEPTH);
        chk("count", 32'(count), 32'(sz));
        chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
        chk("RegWr", 32'(RegWr), 32'(exp_wr));
        chk("RW", 32'(RW), (sz == 0) ? 32'd0 : 32'(q[0].dst));
        chk("busW", busW, (sz == 0) ? 32'd0 : q[0].data);
        model_lookup(RA, h, f);
        chk("hitA", 32'(hitA), 32'(h));
        chk("fwdA", fwdA, f);
        model_lookup(RB, h, f);
        chk("hitB", 32'(hitB), 32'(h));
        chk("fwdB", fwdB, f);
        @(posedge clock);
        if (flush) begin
            q.delete();
        end else begin
            if (exp_wr) void'(q.pop_front());
            if (acc && (in_dst != 5'd0)) begin
                e.dst  = in_dst;
                e.data = in_data;
                q.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_dst   = 5'd0;
        in_data  = 32'd0;
        drain_en = 1'b1;
        RA       = 5'd1;
        RB       = 5'd2;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_RegWr", 32'(RegWr), 32'd0);
        chk("rst_RW", 32'(RW), 32'd0);
        chk("rst_busW", busW, 32'd0);
        chk("rst_hitA", 32'(hitA), 32'd0);
        chk("rst_fwdB", fwdB, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic write with one-cycle latency
        drain_en = 1'b1;
        offer(5'd5, 32'h1234);
        step();
        in_valid = 1'b0;
        #1;
        chk("basic_RegWr", 32'(RegWr), 32'd1);
        chk("basic_RW", 32'(RW), 32'd5);
        chk("basic_busW", busW, 32'h1234);
        step();
        #1;
        chk("basic_RegWr_after", 32'(RegWr), 32'd0);
        chk("basic_count_after", 32'(count), 32'd0);

        // Fill to full, reject a fifth offer, then drain in order
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            offer(5'(i), 32'hA0 + 32'(i));
            step();
        end
        offer(5'd9, 32'hBAD);
        step();
        in_valid = 1'b0;
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drain_en = 1'b1;
        offer(5'd9, 32'hBAD);
        step();
        in_valid = 1'b0;
        repeat (4) step();

        // Newest-value forwarding, lookup ignores live inputs
        drain_en = 1'b0;
        offer(5'd7, 32'h11);
        step();
        offer(5'd7, 32'h22);
        step();
        in_valid = 1'b0;
        RA = 5'd7;
        RB = 5'd8;
        #1;
        chk("fwd_hitA", 32'(hitA), 32'd1);
        chk("fwd_fwdA", fwdA, 32'h22);
        chk("fwd_hitB", 32'(hitB), 32'd0);
        chk("fwd_fwdB", fwdB, 32'd0);
        offer(5'd7, 32'h33);
        #1;
        chk("fwd_scope", fwdA, 32'h22);
        step();
        in_valid = 1'b0;
        #1;
        chk("fwd_new", fwdA, 32'h33);
        drain_en = 1'b1;
        repeat (4) step();

        // Register zero is swallowed
        RA = 5'd0;
        offer(5'd0, 32'hFFFF);
        step();
        in_valid = 1'b0;
        #1;
        chk("zero_count", 32'(count), 32'd0);
        chk("zero_RegWr", 32'(RegWr), 32'd0);
        chk("zero_hitA", 32'(hitA), 32'd0);
        step();

        // Simultaneous enqueue/dequeue across pointer wrap
        drain_en = 1'b0;
        RA = 5'd12;
        RB = 5'd3;
        offer(5'd3, 32'h100);
        step();
        offer(5'd4, 32'h101);
        step();
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(5'(10 + i), 32'h200 + 32'(i));
            step();
            chk("wrap_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Flush overrides simultaneous enqueue and dequeue
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(5'(20 + i), 32'h300 + 32'(i));
            step();
        end
        flush    = 1'b1;
        drain_en = 1'b1;
        offer(5'd9, 32'h999);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        drain_en = 1'b0;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step();

        // Asynchronous reset mid-cycle discards pending entries
        RA = 5'd25;
        offer(5'd25, 32'h400);
        step();
        offer(5'd26, 32'h401);
        step();
        in_valid = 1'b0;
        #1;
        chk("refill_count", 32'(count), 32'd2);
        #1;
        reset    = 1'b1;
        drain_en = 1'b1;
        #1;
        q.delete();
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_RegWr", 32'(RegWr), 32'd0);
        chk("arst_RW", 32'(RW), 32'd0);
        chk("arst_busW", busW, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_hitA", 32'(hitA), 32'd0);
        chk("arst_fwdA", fwdA, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
